// File: rtl/ff_pkg.sv
// Shared Forward-Forward types and Q16.16 constants for the ReLU/goodness stage.
// Includes the saturating unsigned accumulator add.
package ff_pkg;

    localparam int NUM_NEURONS = 256;
    localparam int DATA_WIDTH  = 32;
    localparam int FRAC_BITS   = 16;
    localparam int GOOD_WIDTH  = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    function automatic logic [63:0] sat_add_u64(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[64] ? {64{1'b1}} : s[63:0];
    endfunction

endpackage

// File: rtl/relu_goodness_unit_if.sv
// MAC write stream in, activation buffer and goodness report out.
// GOODNESS_THRESHOLD_EN adds theta / is_positive.
interface relu_goodness_unit_if #(
    parameter int NUM_NEURONS = 256,
    parameter int DATA_WIDTH  = 32,
    parameter int GOOD_WIDTH  = 64
);
    // One spare index bit so out-of-range neuron indices reach the range check.
    localparam int AW = $clog2(NUM_NEURONS) + 1;

    logic                  start;
    logic                  in_we;
    logic [AW-1:0]         in_addr;
    logic [DATA_WIDTH-1:0] in_wdata;
    logic                  layer_done;
    logic [DATA_WIDTH-1:0] act_out [NUM_NEURONS];
    logic [GOOD_WIDTH-1:0] goodness;
    logic                  goodness_vld;
    logic                  busy;
    logic                  err;
`ifdef GOODNESS_THRESHOLD_EN
    logic [GOOD_WIDTH-1:0] theta;
    logic                  is_positive;
`endif

    modport master (
`ifdef GOODNESS_THRESHOLD_EN
        output theta,
        input  is_positive,
`endif
        output start, in_we, in_addr, in_wdata, layer_done,
        input  act_out, goodness, goodness_vld, busy, err
    );

    modport slave (
`ifdef GOODNESS_THRESHOLD_EN
        input  theta,
        output is_positive,
`endif
        input  start, in_we, in_addr, in_wdata, layer_done,
        output act_out, goodness, goodness_vld, busy, err
    );

endinterface

// File: rtl/relu_goodness_unit_relu_square.sv
// Combinational ReLU of a signed Q16.16 value and its Q16.16 square, unsigned and widened.
// Zero latency; no flow control.
module relu_square
    import ff_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int GOOD_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] pre_i,
    output logic [DATA_WIDTH-1:0] relu_o,
    output logic [GOOD_WIDTH-1:0] sq_o
);

    logic [GOOD_WIDTH-1:0] r_wide;

    always_comb begin
        relu_o = pre_i[DATA_WIDTH-1] ? '0 : pre_i;
        r_wide = {{(GOOD_WIDTH-DATA_WIDTH){1'b0}}, relu_o};
        sq_o   = (r_wide * r_wide) >> FRAC_BITS;
    end

endmodule

// File: rtl/relu_goodness_unit.sv
// ReLU activation buffer plus Forward-Forward goodness sum(relu(h)^2); GOODNESS_THRESHOLD_EN adds theta compare.
// Latency: activation 1 cycle; goodness_vld 2 cycles after the layer_done sample.
// Backpressure: none; every in_we inside a pass is consumed, out-of-pass or out-of-range writes set err.
module relu_goodness_unit
    import ff_pkg::*;
#(
    parameter int NUM_NEURONS = 256,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int GOOD_WIDTH  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    relu_goodness_unit_if.slave bus
);

    localparam int AW = $clog2(NUM_NEURONS) + 1;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] act_q [NUM_NEURONS];
    logic [GOOD_WIDTH-1:0] acc_q, sq_q, good_q;
    logic                  sq_vld_q, good_vld_q, err_q;
    logic [31:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] relu_w;
    logic [GOOD_WIDTH-1:0] sq_w;
    logic                  in_window, addr_ok, accept, err_set;
`ifdef GOODNESS_THRESHOLD_EN
    logic                  pos_q;
`endif

    relu_square #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .GOOD_WIDTH(GOOD_WIDTH)
    ) u_relu_square (
        .pre_i (bus.in_wdata),
        .relu_o(relu_w),
        .sq_o  (sq_w)
    );

    // A start cycle already belongs to the new pass, so its sample is accepted.
    always_comb begin
        in_window = bus.start || (state_q == ACCUM);
        addr_ok   = bus.in_addr < AW'(NUM_NEURONS);
        accept    = bus.in_we && in_window && addr_ok;
        cnt_d     = (bus.start ? 32'd0 : cnt_q) + (accept ? 32'd1 : 32'd0);
        err_set   = (bus.in_we && !addr_ok)
                 || (bus.in_we && !in_window)
                 || (!bus.start && state_q == ACCUM && bus.layer_done
                     && cnt_d != 32'(NUM_NEURONS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            sq_q       <= '0;
            sq_vld_q   <= 1'b0;
            cnt_q      <= '0;
            good_q     <= '0;
            good_vld_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef GOODNESS_THRESHOLD_EN
            pos_q      <= 1'b0;
`endif
        end else begin
            good_vld_q <= 1'b0;
            sq_vld_q   <= accept;
            if (accept) sq_q <= sq_w;
            cnt_q      <= cnt_d;
            err_q      <= (bus.start ? 1'b0 : err_q) | err_set;
            if (bus.start)     acc_q <= '0;
            else if (sq_vld_q) acc_q <= sat_add_u64(acc_q, sq_q);
            if (bus.start) begin
                state_q <= ACCUM;
            end else begin
                case (state_q)
                    ACCUM:   if (bus.layer_done) state_q <= DRAIN;
                    DRAIN:   state_q <= REPORT;
                    REPORT: begin
                        state_q    <= IDLE;
                        good_q     <= acc_q;
                        good_vld_q <= 1'b1;
`ifdef GOODNESS_THRESHOLD_EN
                        pos_q      <= acc_q > bus.theta;
`endif
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) act_q[i] <= '0;
        end else if (accept) begin
            act_q[bus.in_addr[AW-2:0]] <= relu_w;
        end
    end

    assign bus.act_out      = act_q;
    assign bus.goodness     = good_q;
    assign bus.goodness_vld = good_vld_q;
    assign bus.busy         = (state_q == ACCUM) || (state_q == DRAIN);
    assign bus.err          = err_q;
`ifdef GOODNESS_THRESHOLD_EN
    assign bus.is_positive  = pos_q;
`endif

endmodule
